// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code parser: resolves E0/F0 prefixes into key events on a valid/ready handshake,
// tracks held keys in a small table, suppresses typematic repeats and counts presses.
module ps2_key_tracker #(
  parameter int unsigned HELD_SLOTS    = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned FILTER_REPEAT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_release,
  output logic [CNT_W-1:0] press_cnt,
  output logic [8:0]       last_code,
  output logic [3:0]       held_num,
  output logic             any_held,
  output logic             held_overrun,
  output logic             ovf_seen
);

  typedef enum logic [1:0] {StIdle, StPop, StDecode, StEmit} state_e;

  state_e                       state_q, state_d;
  logic [7:0]                   byte_q, byte_d;
  logic                         ext_p_q, ext_p_d;
  logic                         brk_p_q, brk_p_d;
  logic                         nextdata_n_q;
  logic [7:0]                   code_q, code_d;
  logic                         ext_q, ext_d;
  logic                         rel_q, rel_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [8:0]                   last_q, last_d;
  logic                         overrun_q, overrun_d;
  logic                         ovf_q;
  logic [HELD_SLOTS-1:0]        slot_vld_q, slot_vld_d;
  logic [HELD_SLOTS-1:0][8:0]   slot_key_q, slot_key_d;

  logic [8:0]            key;
  logic                  hit;
  logic [HELD_SLOTS-1:0] hit_oh;
  logic                  free;
  logic [HELD_SLOTS-1:0] free_oh;
  logic [3:0]            held_cnt;

  // Table lookup: keys are unique, so at most one hit; free_oh picks the lowest empty slot.
  always_comb begin
    key     = {ext_p_q, byte_q};
    hit     = 1'b0;
    hit_oh  = '0;
    free    = 1'b0;
    free_oh = '0;
    for (int i = 0; i < HELD_SLOTS; i++) begin
      if (slot_vld_q[i] && (slot_key_q[i] == key) && !hit) begin
        hit       = 1'b1;
        hit_oh[i] = 1'b1;
      end
      if (!slot_vld_q[i] && !free) begin
        free       = 1'b1;
        free_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    held_cnt = '0;
    for (int i = 0; i < HELD_SLOTS; i++) begin
      held_cnt = held_cnt + 4'(slot_vld_q[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    ext_p_d    = ext_p_q;
    brk_p_d    = brk_p_q;
    code_d     = code_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    overrun_d  = overrun_q;
    slot_vld_d = slot_vld_q;
    slot_key_d = slot_key_q;
    unique case (state_q)
      StIdle: begin
        if (kb_ready) begin
          byte_d  = kb_data;
          state_d = StPop;
        end
      end
      StPop: state_d = StDecode;
      StDecode: begin
        state_d = StIdle;
        if (byte_q == 8'hE0) begin
          ext_p_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_p_d = 1'b1;
        end else begin
          ext_p_d = 1'b0;
          brk_p_d = 1'b0;
          if ((byte_q == 8'h00) || (byte_q == 8'hFF)) begin
            state_d = StIdle;
          end else if (brk_p_q) begin
            slot_vld_d = slot_vld_q & ~hit_oh;
            code_d     = byte_q;
            ext_d      = ext_p_q;
            rel_d      = 1'b1;
            state_d    = StEmit;
          end else if (hit && (FILTER_REPEAT != 0)) begin
            state_d = StIdle;
          end else begin
            if (!hit) begin
              if (free) begin
                slot_vld_d = slot_vld_q | free_oh;
                for (int i = 0; i < HELD_SLOTS; i++) begin
                  if (free_oh[i]) slot_key_d[i] = key;
                end
              end else begin
                overrun_d = 1'b1;
              end
            end
            cnt_d   = cnt_q + CNT_W'(1);
            last_d  = key;
            code_d  = byte_q;
            ext_d   = ext_p_q;
            rel_d   = 1'b0;
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        if (evt_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      byte_q       <= '0;
      ext_p_q      <= 1'b0;
      brk_p_q      <= 1'b0;
      nextdata_n_q <= 1'b1;
      code_q       <= '0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      cnt_q        <= '0;
      last_q       <= '0;
      overrun_q    <= 1'b0;
      ovf_q        <= 1'b0;
      slot_vld_q   <= '0;
      slot_key_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      ext_p_q      <= ext_p_d;
      brk_p_q      <= brk_p_d;
      // Strobe is low for exactly the POP cycle.
      nextdata_n_q <= (state_d != StPop);
      code_q       <= code_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      overrun_q    <= overrun_d;
      ovf_q        <= ovf_q | kb_overflow;
      slot_vld_q   <= slot_vld_d;
      slot_key_q   <= slot_key_d;
    end
  end

  assign kb_nextdata_n = nextdata_n_q;
  assign evt_valid     = (state_q == StEmit);
  assign evt_code      = code_q;
  assign evt_ext       = ext_q;
  assign evt_release   = rel_q;
  assign press_cnt     = cnt_q;
  assign last_code     = last_q;
  assign held_num      = held_cnt;
  assign any_held      = (held_cnt != 4'd0);
  assign held_overrun  = overrun_q;
  assign ovf_seen      = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: default instance plus a FILTER_REPEAT=0, CNT_W=2 instance.
module tb_ps2_key_tracker;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [7:0] kb_data0, kb_data1;
  logic       kb_ready0, kb_ready1, kb_ovf0, kb_ovf1;
  logic       nd0, nd1, ev0, ev1, er0, er1;
  logic [7:0] code0, code1;
  logic       ext0, ext1, rel0, rel1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [8:0] last0, last1;
  logic [3:0] held0, held1;
  logic       any0, any1, ovr0, ovr1, ovfs0, ovfs1;

  ps2_key_tracker u_dut0 (
    .clk(clk), .resetn(resetn), .kb_data(kb_data0), .kb_ready(kb_ready0),
    .kb_overflow(kb_ovf0), .kb_nextdata_n(nd0), .evt_valid(ev0), .evt_ready(er0),
    .evt_code(code0), .evt_ext(ext0), .evt_release(rel0), .press_cnt(cnt0),
    .last_code(last0), .held_num(held0), .any_held(any0), .held_overrun(ovr0),
    .ovf_seen(ovfs0)
  );

  ps2_key_tracker #(.HELD_SLOTS(4), .CNT_W(2), .FILTER_REPEAT(0)) u_dut1 (
    .clk(clk), .resetn(resetn), .kb_data(kb_data1), .kb_ready(kb_ready1),
    .kb_overflow(kb_ovf1), .kb_nextdata_n(nd1), .evt_valid(ev1), .evt_ready(er1),
    .evt_code(code1), .evt_ext(ext1), .evt_release(rel1), .press_cnt(cnt1),
    .last_code(last1), .held_num(held1), .any_held(any1), .held_overrun(ovr1),
    .ovf_seen(ovfs1)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] cnt;
    logic [8:0] last;
    logic [3:0] held;
    logic       ovr;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   n_cmp = 0, n_bad = 0;
  int   pops0 = 0, pops1 = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(logic [7:0] c, logic x, logic r, logic [7:0] n, logic [8:0] l,
                              logic [3:0] h, logic o);
    mk = '{code: c, ext: x, rel: r, cnt: n, last: l, held: h, ovr: o};
  endfunction

  // Monitors: count pop strobes and score every accepted event.
  always @(negedge clk) begin
    if (resetn) begin
      if (nd0 === 1'b0) pops0++;
      if (ev0 && er0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dut0_unexpected_event: got code %0h expected no event", code0);
        end else begin
          e0 = q0.pop_front();
          check("dut0_code", 32'(code0), 32'(e0.code));
          check("dut0_ext", 32'(ext0), 32'(e0.ext));
          check("dut0_release", 32'(rel0), 32'(e0.rel));
          check("dut0_press_cnt", 32'(cnt0), 32'(e0.cnt));
          check("dut0_last_code", 32'(last0), 32'(e0.last));
          check("dut0_held_num", 32'(held0), 32'(e0.held));
          check("dut0_any_held", 32'(any0), 32'(e0.held != 0));
          check("dut0_overrun", 32'(ovr0), 32'(e0.ovr));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (nd1 === 1'b0) pops1++;
      if (ev1 && er1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dut1_unexpected_event: got code %0h expected no event", code1);
        end else begin
          e1 = q1.pop_front();
          check("dut1_code", 32'(code1), 32'(e1.code));
          check("dut1_ext", 32'(ext1), 32'(e1.ext));
          check("dut1_release", 32'(rel1), 32'(e1.rel));
          check("dut1_press_cnt", 32'(cnt1), 32'(e1.cnt));
          check("dut1_last_code", 32'(last1), 32'(e1.last));
          check("dut1_held_num", 32'(held1), 32'(e1.held));
          check("dut1_overrun", 32'(ovr1), 32'(e1.ovr));
        end
      end
    end
  end

  // Presents one byte as FIFO head and returns during the POP cycle.
  task automatic send(input int u, input logic [7:0] b);
    int t;
    if (u == 0) begin kb_data0 = b; kb_ready0 = 1'b1; end
    else begin kb_data1 = b; kb_ready1 = 1'b1; end
    t = 0;
    forever begin
      @(negedge clk);
      t++;
      if ((u == 0) ? (nd0 === 1'b0) : (nd1 === 1'b0)) break;
      if (t > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL pop_timeout: dut%0d byte %0h got no pop expected pop", u, b);
        break;
      end
    end
    if (u == 0) kb_ready0 = 1'b0; else kb_ready1 = 1'b0;
  endtask

  task automatic drain(input int u);
    int t;
    t = 0;
    while (((u == 0) ? q0.size() : q1.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("dut%0d_drain_left", u), (u == 0) ? q0.size() : q1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset0(string tag);
    check({tag, "_nextdata_n"}, 32'(nd0), 1);
    check({tag, "_valid"}, 32'(ev0), 0);
    check({tag, "_code"}, 32'(code0), 0);
    check({tag, "_ext"}, 32'(ext0), 0);
    check({tag, "_release"}, 32'(rel0), 0);
    check({tag, "_press_cnt"}, 32'(cnt0), 0);
    check({tag, "_last_code"}, 32'(last0), 0);
    check({tag, "_held_num"}, 32'(held0), 0);
    check({tag, "_any_held"}, 32'(any0), 0);
    check({tag, "_overrun"}, 32'(ovr0), 0);
    check({tag, "_ovf_seen"}, 32'(ovfs0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    resetn = 1'b0;
    kb_data0 = '0; kb_ready0 = 1'b0; kb_ovf0 = 1'b0; er0 = 1'b1;
    kb_data1 = '0; kb_ready1 = 1'b0; kb_ovf1 = 1'b0; er1 = 1'b1;
    repeat (3) @(negedge clk);
    check_reset0("reset");
    check("reset_dut1_press_cnt", 32'(cnt1), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Make 1C with cycle-accurate latency.
    q0.push_back(mk(8'h1C, 0, 0, 8'd1, 9'h01C, 4'd1, 0));
    kb_data0 = 8'h1C; kb_ready0 = 1'b1;
    @(negedge clk);
    check("lat_pop_low", 32'(nd0), 0);
    check("lat_pop_valid", 32'(ev0), 0);
    kb_ready0 = 1'b0;
    @(negedge clk);
    check("lat_decode_nd", 32'(nd0), 1);
    check("lat_decode_valid", 32'(ev0), 0);
    @(negedge clk);
    check("lat_emit_valid", 32'(ev0), 1);

    q0.push_back(mk(8'h1C, 0, 1, 8'd1, 9'h01C, 4'd0, 0));
    send(0, 8'hF0); send(0, 8'h1C);
    drain(0);
    check("break_pops", pops0, 3);

    q0.push_back(mk(8'h75, 1, 0, 8'd2, 9'h175, 4'd1, 0));
    send(0, 8'hE0); send(0, 8'h75);
    q0.push_back(mk(8'h75, 1, 1, 8'd2, 9'h175, 4'd0, 0));
    send(0, 8'hE0); send(0, 8'hF0); send(0, 8'h75);

    // Typematic repeats are filtered.
    q0.push_back(mk(8'h1C, 0, 0, 8'd3, 9'h01C, 4'd1, 0));
    send(0, 8'h1C); send(0, 8'h1C); send(0, 8'h1C);
    q0.push_back(mk(8'h1C, 0, 1, 8'd3, 9'h01C, 4'd0, 0));
    send(0, 8'hF0); send(0, 8'h1C);
    drain(0);
    check("typematic_pops", pops0, 13);

    // Fill the table past capacity.
    q0.push_back(mk(8'h15, 0, 0, 8'd4, 9'h015, 4'd1, 0)); send(0, 8'h15);
    q0.push_back(mk(8'h1D, 0, 0, 8'd5, 9'h01D, 4'd2, 0)); send(0, 8'h1D);
    q0.push_back(mk(8'h24, 0, 0, 8'd6, 9'h024, 4'd3, 0)); send(0, 8'h24);
    q0.push_back(mk(8'h2D, 0, 0, 8'd7, 9'h02D, 4'd4, 0)); send(0, 8'h2D);
    q0.push_back(mk(8'h2C, 0, 0, 8'd8, 9'h02C, 4'd4, 1)); send(0, 8'h2C);
    q0.push_back(mk(8'h2C, 0, 1, 8'd8, 9'h02C, 4'd4, 1));
    send(0, 8'hF0); send(0, 8'h2C);
    drain(0);

    // Backpressure: event held, no further pops; then reset mid-EMIT discards it.
    er0 = 1'b0;
    send(0, 8'h33);
    repeat (2) @(negedge clk);
    check("bp_valid_start", 32'(ev0), 1);
    kb_data0 = 8'h44; kb_ready0 = 1'b1;
    kb_ovf0 = 1'b1;
    p = pops0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      kb_ovf0 = 1'b0;
      check("bp_valid", 32'(ev0), 1);
      check("bp_code", 32'(code0), 32'h33);
      check("bp_ext_rel", 32'({ext0, rel0}), 0);
      check("bp_press_cnt", 32'(cnt0), 9);
      check("bp_last_code", 32'(last0), 32'h033);
      check("bp_held_num", 32'(held0), 4);
    end
    check("bp_no_pops", pops0, p);
    check("ovf_seen_set", 32'(ovfs0), 1);
    resetn = 1'b0; kb_ready0 = 1'b0; er0 = 1'b1;
    @(negedge clk);
    check_reset0("mid_emit_reset");
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_valid", 32'(ev0), 0);

    // Unfiltered repeats and counter wrap on the second instance.
    q1.push_back(mk(8'h1C, 0, 0, 8'd1, 9'h01C, 4'd1, 0)); send(1, 8'h1C);
    q1.push_back(mk(8'h1C, 0, 0, 8'd2, 9'h01C, 4'd1, 0)); send(1, 8'h1C);
    q1.push_back(mk(8'h1C, 0, 0, 8'd3, 9'h01C, 4'd1, 0)); send(1, 8'h1C);
    q1.push_back(mk(8'h22, 0, 0, 8'd0, 9'h022, 4'd2, 0)); send(1, 8'h22);
    q1.push_back(mk(8'h23, 0, 0, 8'd1, 9'h023, 4'd3, 0)); send(1, 8'h23);
    drain(1);
    check("wrap_press_cnt", 32'(cnt1), 1);
    check("wrap_pops", pops1, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
